// File: rtl/vco_band_cal_pkg.sv
// Shared types and defaults for the VCO coarse-band calibrator.
// Holds the FSM state encoding, default parameters and a helper.
package vco_band_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DECIDE,
    VERIFY,
    DONE
  } state_t;

  localparam int TUNE_W_DEF     = 5;
  localparam int CNT_W_DEF      = 16;
  localparam int WIN_CYC_DEF    = 256;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int TOL_DEF        = 4;

  localparam logic [TUNE_W_DEF-1:0] TUNE_MID = 5'b10000;

  function automatic int unsigned abs_diff(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/vco_band_cal_sync_edge_det.sv
// Two-flop synchronizer plus rising-edge pulse for async inputs.
// One registered pulse per input rising edge, 3 clocks latency.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], level};
      pulse <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/vco_band_cal.sv
// SAR coarse-band calibration of the CDR VCO tune code.
// Define VCO_BAND_CAL_VERIFY_EN to add a final tolerance check pass.
module vco_band_cal
  import vco_band_cal_pkg::*;
#(
  parameter int TUNE_W     = TUNE_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_CYC    = WIN_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TOL        = TOL_DEF
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              vco_div,
  input  logic [CNT_W-1:0]  target_cnt,
  output logic [TUNE_W-1:0] tune,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  meas_cnt,
  output logic              cal_err
);

  localparam int TMAX =
    (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam int KW = (TUNE_W > 1) ? $clog2(TUNE_W) : 1;
  localparam logic [TUNE_W-1:0] MID =
    (TUNE_W == TUNE_W_DEF) ? TUNE_W'(TUNE_MID)
                           : (TUNE_W'(1) << (TUNE_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [CNT_W-1:0]  edge_cnt;
  logic [KW-1:0]     bit_idx;
  logic [TUNE_W-1:0] dec_tune;
  logic              edge_pulse;

`ifdef VCO_BAND_CAL_VERIFY_EN
  logic vpass;
  logic err_q;
  assign cal_err = err_q;
`else
  assign cal_err = 1'b0;
`endif

  sync_edge_det u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .level (vco_div),
    .pulse (edge_pulse)
  );

  // Too fast clears the bit under test; next lower bit is trialled.
  always_comb begin
    dec_tune = tune;
    if (edge_cnt > target_cnt)
      dec_tune[bit_idx] = 1'b0;
    if (bit_idx != '0)
      dec_tune[bit_idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tune     <= MID;
      busy     <= 1'b0;
      done     <= 1'b0;
      meas_cnt <= '0;
      tmr      <= '0;
      edge_cnt <= '0;
      bit_idx  <= '0;
`ifdef VCO_BAND_CAL_VERIFY_EN
      vpass    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            tune    <= MID;
            bit_idx <= KW'(TUNE_W - 1);
            busy    <= 1'b1;
            done    <= 1'b0;
            tmr     <= '0;
            state   <= SETTLE;
`ifdef VCO_BAND_CAL_VERIFY_EN
            vpass   <= 1'b0;
            err_q   <= 1'b0;
`endif
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
            tmr      <= '0;
            edge_cnt <= '0;
            state    <= MEASURE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        MEASURE: begin
          if (edge_pulse && edge_cnt != CNT_MAX)
            edge_cnt <= edge_cnt + 1'b1;
          if (tmr == TMR_W'(WIN_CYC - 1)) begin
            tmr   <= '0;
            state <= DECIDE;
`ifdef VCO_BAND_CAL_VERIFY_EN
            if (vpass)
              state <= VERIFY;
`endif
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DECIDE: begin
          meas_cnt <= edge_cnt;
          tune     <= dec_tune;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            state   <= SETTLE;
          end else begin
`ifdef VCO_BAND_CAL_VERIFY_EN
            vpass <= 1'b1;
            state <= SETTLE;
`else
            state <= DONE;
`endif
          end
        end
        VERIFY: begin
`ifdef VCO_BAND_CAL_VERIFY_EN
          meas_cnt <= edge_cnt;
          err_q    <= abs_diff(32'(edge_cnt), 32'(target_cnt))
                      > int unsigned'(TOL);
          state    <= DONE;
`else
          state    <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
